// File: rtl/check_a2d_sar_nch_if.sv
`default_nettype none
// ============================================================================
// Module  : check_a2d_sar_nch_if
// Brief   : control handshake and DAC code bus of the SAR offset extractor
// Revision: 1.0 - initial release
// ============================================================================
interface check_a2d_sar_nch_if #(
  parameter int NCH    = 4,
  parameter int CODE_W = 8
);
  logic                    start;
  logic                    track_en;
  logic [NCH-1:0]          ch_en;
  logic [NCH-1:0]          comp_out;
  logic [NCH*CODE_W-1:0]   code;
  logic                    busy;
  logic                    done;
  logic                    code_valid;

  modport master (
    output start, track_en, ch_en, comp_out,
    input  code, busy, done, code_valid
  );

  modport slave (
    input  start, track_en, ch_en, comp_out,
    output code, busy, done, code_valid
  );
endinterface
`default_nettype wire

// File: rtl/check_a2d_sar_nch.sv
`default_nettype none
// ============================================================================
// Module  : check_a2d_sar_nch
// Brief   : multi-channel SAR search of comparator offset, optional 1-LSB tracking
// Revision: 1.0 - initial release
// ============================================================================
module check_a2d_sar_nch #(
  parameter int             NCH     = 4,
  parameter int             CODE_W  = 8,
  parameter int             NSETTLE = 1,
  parameter int             MAJ_N   = 1,
  parameter logic [NCH-1:0] INVERT  = '0
) (
  input  logic               virclk,
  input  logic               rstn,
  check_a2d_sar_nch_if.slave bus
);

  localparam int c_CNT_MAX = (NSETTLE > MAJ_N) ? NSETTLE : MAJ_N;
  localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
  localparam int c_ONES_W  = $clog2(MAJ_N + 1);
  localparam int c_K_W     = $clog2(CODE_W);

  localparam logic [c_CNT_W-1:0]     c_SETTLE_LAST = c_CNT_W'(NSETTLE - 1);
  localparam logic [c_CNT_W-1:0]     c_SAMPLE_LAST = c_CNT_W'(MAJ_N - 1);
  localparam logic [c_ONES_W-1:0]    c_HALF        = c_ONES_W'(MAJ_N / 2);
  localparam logic [c_K_W-1:0]       c_K_LAST      = c_K_W'(CODE_W - 2);
  localparam logic [CODE_W:0]        c_STEP_ONE    = {{CODE_W{1'b0}}, 1'b1};
  localparam logic [CODE_W:0]        c_STEP_FIRST  = c_STEP_ONE << (CODE_W - 2);
  localparam logic signed [CODE_W:0] c_CODE_MAX    = $signed({2'b00, {(CODE_W-1){1'b1}}});
  localparam logic signed [CODE_W:0] c_CODE_MIN    = -c_CODE_MAX;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_SAMPLE = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_busy;
  logic               w_done;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_K_W-1:0]   r_k;
  logic               r_track;
  logic               r_code_valid;
  logic [CODE_W:0]    w_step;

  always_ff @(posedge virclk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: if (r_cnt == c_SETTLE_LAST) w_state_nxt = S_SAMPLE;
      S_SAMPLE: if (r_cnt == c_SAMPLE_LAST) w_state_nxt = S_UPDATE;
      S_UPDATE: begin
        if (r_track)              w_state_nxt = bus.track_en ? S_SETTLE : S_IDLE;
        else if (r_k == c_K_LAST) w_state_nxt = S_DONE;
        else                      w_state_nxt = S_SETTLE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = bus.track_en ? S_SETTLE : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Dwell counter restarts on every state change, so it times both SETTLE and SAMPLE.
  always_ff @(posedge virclk or negedge rstn) begin
    if (!rstn)                                             r_cnt <= '0;
    else if (w_state_nxt != r_state)                       r_cnt <= '0;
    else if (r_state == S_SETTLE || r_state == S_SAMPLE)   r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge virclk or negedge rstn) begin
    if (!rstn) begin
      r_k          <= '0;
      r_track      <= 1'b0;
      r_code_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_k          <= '0;
            r_track      <= 1'b0;
            r_code_valid <= 1'b0;
          end
        end
        S_UPDATE: begin
          if (!r_track) begin
            r_k <= r_k + 1'b1;
            if (r_k == c_K_LAST) r_code_valid <= 1'b1;
          end
        end
        S_DONE:  r_track <= bus.track_en;
        default: ;
      endcase
    end
  end

  // Binary weight halves each search step; tracking always moves one LSB.
  assign w_step = r_track ? c_STEP_ONE : (c_STEP_FIRST >> r_k);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic signed [CODE_W-1:0] r_code;
    logic [c_ONES_W-1:0]      r_ones;
    logic signed [CODE_W:0]   w_ext;
    logic signed [CODE_W:0]   w_sum;
    logic                     w_dir;
    logic signed [CODE_W-1:0] w_code_nxt;

    assign w_ext = {r_code[CODE_W-1], r_code};
    assign w_dir = (r_ones > c_HALF) ^ INVERT[gi];
    assign w_sum = w_dir ? (w_ext - $signed(w_step)) : (w_ext + $signed(w_step));

    // Clamp only bites in tracking; search sums never exceed full scale.
    always_comb begin
      w_code_nxt = w_sum[CODE_W-1:0];
      if (w_sum > c_CODE_MAX)      w_code_nxt = c_CODE_MAX[CODE_W-1:0];
      else if (w_sum < c_CODE_MIN) w_code_nxt = c_CODE_MIN[CODE_W-1:0];
      if (!bus.ch_en[gi])          w_code_nxt = '0;
    end

    always_ff @(posedge virclk or negedge rstn) begin
      if (!rstn) begin
        r_code <= '0;
        r_ones <= '0;
      end else begin
        case (r_state)
          S_IDLE:   if (bus.start) r_code <= '0;
          S_SETTLE: r_ones <= '0;
          S_SAMPLE: r_ones <= r_ones + c_ONES_W'(bus.comp_out[gi]);
          S_UPDATE: r_code <= w_code_nxt;
          default:  ;
        endcase
      end
    end

    assign bus.code[gi*CODE_W +: CODE_W] = r_code;
  end

  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.code_valid = r_code_valid;

endmodule
`default_nettype wire

// File: tb/tb_check_a2d_sar_nch.sv
`default_nettype none
// Bench for check_a2d_sar_nch: plain instance (A) and inverted, 3-vote instance (B)
// driven by ideal comparators whose trip points are the per-channel targets.
module tb_check_a2d_sar_nch;
  localparam int CW   = 6;
  localparam int P_A  = 3;   // settle + sample + update cycles per step, instance A
  localparam int P_B  = 5;   // same for instance B (three votes)
  localparam int CMAX = 31;

  typedef struct {
    int         t0;
    int         t1;
    logic [1:0] en;
    int         e0;
    int         e1;
  } vec_t;

  logic virclk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   tgt_a [2];
  int   tgt_b [2];
  logic noise_b;
  int   n_checks = 0;
  int   n_fail = 0;
  int   mc [2];
  int   traj0 [5] = '{16, 8, 12, 14, 13};
  int   traj1 [5] = '{-16, -8, -4, -6, -7};
  vec_t vecs [6];

  always #5 virclk = ~virclk;
  always @(posedge virclk) cyc <= cyc + 1;

  check_a2d_sar_nch_if #(.NCH(2), .CODE_W(CW)) bus_a ();
  check_a2d_sar_nch_if #(.NCH(2), .CODE_W(CW)) bus_b ();

  check_a2d_sar_nch #(.NCH(2), .CODE_W(CW), .NSETTLE(1), .MAJ_N(1), .INVERT(2'b00)) dut_a (
    .virclk(virclk), .rstn(rstn), .bus(bus_a));
  check_a2d_sar_nch #(.NCH(2), .CODE_W(CW), .NSETTLE(1), .MAJ_N(3), .INVERT(2'b10)) dut_b (
    .virclk(virclk), .rstn(rstn), .bus(bus_b));

  function automatic int code_of(input logic [2*CW-1:0] c, input int i);
    logic signed [CW-1:0] v;
    v = c[i*CW +: CW];
    return int'(v);
  endfunction

  // Noise flips one of every three consecutive cycles, so any 3-sample vote stays correct.
  always_comb begin
    bus_a.comp_out = '0;
    bus_b.comp_out = '0;
    for (int i = 0; i < 2; i++) bus_a.comp_out[i] = code_of(bus_a.code, i) > tgt_a[i];
    bus_b.comp_out[0] = (code_of(bus_b.code, 0) >  tgt_b[0]) ^ (noise_b && (cyc % 3 == 0));
    bus_b.comp_out[1] = (code_of(bus_b.code, 1) <= tgt_b[1]) ^ (noise_b && (cyc % 3 == 0));
  end

  task automatic check(input string name, input integer act, input integer exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampc(input int v);
    return (v > CMAX) ? CMAX : ((v < -CMAX) ? -CMAX : v);
  endfunction

  // A full search always lands on the odd code nearest above an even trip point.
  function automatic int search_result(input int t);
    return clampc((t % 2 == 0) ? t + 1 : t);
  endfunction

  function automatic int track_step(input int c, input int t);
    return clampc((c > t) ? c - 1 : c + 1);
  endfunction

  function automatic int rnd_target();
    return int'($urandom_range(80, 0)) - 40;
  endfunction

  task automatic search_a(input int t0, input int t1, input logic [1:0] en, input logic trk,
                          input int e0, input int e1, input int poke);
    int n;
    tgt_a[0] = t0; tgt_a[1] = t1;
    bus_a.ch_en = en; bus_a.track_en = trk;
    bus_a.start = 1'b1;
    @(negedge virclk);
    bus_a.start = 1'b0;
    n = 1;
    check("a_busy_accept", bus_a.busy, 1);
    check("a_valid_drop", bus_a.code_valid, 0);
    while (bus_a.done !== 1'b1 && n < 40) begin
      @(negedge virclk);
      n++;
      bus_a.start = (n == poke);
    end
    bus_a.start = 1'b0;
    check("a_latency", n, 5 * P_A + 1);
    check("a_code0", code_of(bus_a.code, 0), e0);
    check("a_code1", code_of(bus_a.code, 1), e1);
    check("a_valid_done", bus_a.code_valid, 1);
    mc[0] = e0; mc[1] = e1;
  endtask

  task automatic track_a(input int nt0, input int nt1, input int periods);
    tgt_a[0] = nt0; tgt_a[1] = nt1;
    for (int p = 0; p < periods; p++) begin
      repeat (p == 0 ? 4 : 3) @(negedge virclk);
      for (int i = 0; i < 2; i++) mc[i] = bus_a.ch_en[i] ? track_step(mc[i], tgt_a[i]) : 0;
      check("trk_code0", code_of(bus_a.code, 0), mc[0]);
      check("trk_code1", code_of(bus_a.code, 1), mc[1]);
      check("trk_busy", bus_a.busy, 1);
      check("trk_valid", bus_a.code_valid, 1);
    end
    bus_a.track_en = 1'b0;
    repeat (3) @(negedge virclk);
    for (int i = 0; i < 2; i++) mc[i] = bus_a.ch_en[i] ? track_step(mc[i], tgt_a[i]) : 0;
    check("trk_last_code0", code_of(bus_a.code, 0), mc[0]);
    check("trk_last_code1", code_of(bus_a.code, 1), mc[1]);
    check("trk_exit_busy", bus_a.busy, 0);
    repeat (3) @(negedge virclk);
    check("trk_hold_code0", code_of(bus_a.code, 0), mc[0]);
    check("trk_hold_valid", bus_a.code_valid, 1);
  endtask

  task automatic search_b(input int t0, input int t1);
    int n;
    tgt_b[0] = t0; tgt_b[1] = t1;
    bus_b.ch_en = 2'b11; bus_b.track_en = 1'b0;
    bus_b.start = 1'b1;
    @(negedge virclk);
    bus_b.start = 1'b0;
    n = 1;
    while (bus_b.done !== 1'b1 && n < 60) begin
      @(negedge virclk);
      n++;
    end
    check("b_latency", n, 5 * P_B + 1);
    check("b_code0", code_of(bus_b.code, 0), search_result(t0));
    check("b_code1", code_of(bus_b.code, 1), search_result(t1));
    @(negedge virclk);
    check("b_idle", bus_b.busy, 0);
    check("b_valid", bus_b.code_valid, 1);
  endtask

  initial begin
    int t0, t1, e0, e1, dn;
    logic [1:0] en;
    logic trk;

    rstn = 1'b0;
    bus_a.start = 1'b0; bus_a.track_en = 1'b0; bus_a.ch_en = 2'b00;
    bus_b.start = 1'b0; bus_b.track_en = 1'b0; bus_b.ch_en = 2'b00;
    tgt_a[0] = 0; tgt_a[1] = 0; tgt_b[0] = 0; tgt_b[1] = 0;
    noise_b = 1'b0;
    vecs[0] = '{13, -7, 2'b11, 13, -7};
    vecs[1] = '{40, -40, 2'b11, 31, -31};
    vecs[2] = '{0, -1, 2'b11, 1, -1};
    vecs[3] = '{30, -32, 2'b11, 31, -31};
    vecs[4] = '{2, -4, 2'b11, 3, -3};
    vecs[5] = '{13, -7, 2'b01, 13, 0};

    repeat (2) @(negedge virclk);
    check("rst_busy", bus_a.busy, 0);
    check("rst_done", bus_a.done, 0);
    check("rst_valid", bus_a.code_valid, 0);
    check("rst_code", bus_a.code, 0);
    check("rst_b_busy", bus_b.busy, 0);
    rstn = 1'b1;
    @(negedge virclk);

    // Step-by-step trajectory of the basic search
    tgt_a[0] = 13; tgt_a[1] = -7; bus_a.ch_en = 2'b11;
    bus_a.start = 1'b1;
    @(negedge virclk);
    bus_a.start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      repeat (3) @(negedge virclk);
      check("traj_code0", code_of(bus_a.code, 0), traj0[j]);
      check("traj_code1", code_of(bus_a.code, 1), traj1[j]);
      check("traj_done", bus_a.done, (j == 4) ? 1 : 0);
    end
    @(negedge virclk);
    check("traj_done_pulse", bus_a.done, 0);
    check("traj_idle", bus_a.busy, 0);
    check("traj_valid", bus_a.code_valid, 1);

    for (int v = 0; v < 6; v++) begin
      search_a(vecs[v].t0, vecs[v].t1, vecs[v].en, 1'b0, vecs[v].e0, vecs[v].e1, 0);
      @(negedge virclk);
      check("vec_done_pulse", bus_a.done, 0);
      check("vec_idle", bus_a.busy, 0);
    end

    // start re-asserted mid-search must not disturb it
    search_a(13, -7, 2'b11, 1'b0, 13, -7, 5);
    @(negedge virclk);
    check("poke_idle", bus_a.busy, 0);

    search_a(13, -7, 2'b11, 1'b1, 13, -7, 0);
    track_a(15, -7, 5);
    search_a(40, -40, 2'b11, 1'b1, 31, -31, 0);
    track_a(40, -40, 3);

    for (int r = 0; r < 12; r++) begin
      t0 = rnd_target(); t1 = rnd_target();
      en = 2'($urandom_range(3, 1));
      trk = 1'($urandom_range(1, 0));
      e0 = en[0] ? search_result(t0) : 0;
      e1 = en[1] ? search_result(t1) : 0;
      search_a(t0, t1, en, trk, e0, e1, 0);
      if (trk) track_a(rnd_target(), rnd_target(), 1 + int'($urandom_range(3, 0)));
      else begin
        @(negedge virclk);
        check("rnd_idle", bus_a.busy, 0);
      end
    end

    // Asynchronous reset in the middle of a search
    tgt_a[0] = 13; tgt_a[1] = -7; bus_a.ch_en = 2'b11; bus_a.track_en = 1'b0;
    bus_a.start = 1'b1;
    @(negedge virclk);
    bus_a.start = 1'b0;
    repeat (6) @(negedge virclk);
    check("pre_rst_code0", code_of(bus_a.code, 0), traj0[1]);
    rstn = 1'b0;
    #1;
    check("mid_rst_busy", bus_a.busy, 0);
    check("mid_rst_done", bus_a.done, 0);
    check("mid_rst_valid", bus_a.code_valid, 0);
    check("mid_rst_code", bus_a.code, 0);
    @(negedge virclk);
    rstn = 1'b1;
    dn = 0;
    repeat (30) begin
      @(negedge virclk);
      if (bus_a.done === 1'b1) dn++;
    end
    check("post_rst_no_done", dn, 0);
    check("post_rst_busy", bus_a.busy, 0);

    noise_b = 1'b1;
    search_b(13, -7);
    for (int r = 0; r < 3; r++) search_b(rnd_target(), rnd_target());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
